// File: rtl/stopwatch_lap.sv
// stopwatch_lap: parametrised BCD up/down stopwatch with prescaler, preset load,
// lap freeze and wrap/saturate overflow policy.
module stopwatch_lap #(
    parameter int TICK_DIV = 50000000,
    parameter int TW       = 26,
    parameter int NDIG     = 3,
    parameter bit WRAP     = 1'b1
) (
    input  logic                clk_i,
    input  logic                clr_ni,
    input  logic                go_i,
    input  logic                down_i,
    input  logic                load_i,
    input  logic [4*NDIG-1:0]   preset_i,
    input  logic                lap_i,
    output logic [4*NDIG-1:0]   count_o,
    output logic [4*NDIG-1:0]   digits_o,
    output logic                frozen_o,
    output logic                step_o,
    output logic                ovf_o,
    output logic                zero_o
);
    localparam logic [4*NDIG-1:0] ALL9  = {NDIG{4'h9}};
    localparam logic [TW-1:0]     TLAST = TW'(TICK_DIV - 1);

    logic [TW-1:0]     tick_q, tick_d;
    logic [4*NDIG-1:0] count_q, count_d, lap_q, lap_d;
    logic              frozen_q, frozen_d, ovf_q, ovf_d;
    logic [4*NDIG-1:0] inc_v, dec_v, ld_v;
    logic              cy, bw, tick_end, all9, blocked;

    // Ripple carry/borrow across digits; preset digits above 9 clamp to 9.
    always_comb begin
        inc_v = count_q;
        dec_v = count_q;
        ld_v  = preset_i;
        cy    = 1'b1;
        bw    = 1'b1;
        for (int k = 0; k < NDIG; k++) begin
            if (cy) begin
                inc_v[4*k +: 4] = (count_q[4*k +: 4] == 4'd9) ? 4'd0 : count_q[4*k +: 4] + 4'd1;
                cy = (count_q[4*k +: 4] == 4'd9);
            end
            if (bw) begin
                dec_v[4*k +: 4] = (count_q[4*k +: 4] == 4'd0) ? 4'd9 : count_q[4*k +: 4] - 4'd1;
                bw = (count_q[4*k +: 4] == 4'd0);
            end
            if (preset_i[4*k +: 4] > 4'd9) ld_v[4*k +: 4] = 4'd9;
        end
    end

    assign tick_end = (tick_q == TLAST);
    assign all9     = (count_q == ALL9);
    assign zero_o   = (count_q == '0);
    assign blocked  = (down_i && zero_o) || (!down_i && !WRAP && all9);
    assign step_o   = go_i && !load_i && tick_end && !blocked;

    always_comb begin
        tick_d   = load_i ? '0 : go_i ? (tick_end ? '0 : tick_q + 1'b1) : tick_q;
        count_d  = load_i ? ld_v : step_o ? (down_i ? dec_v : inc_v) : count_q;
        ovf_d    = load_i ? 1'b0 : (step_o && !down_i && (WRAP ? all9 : inc_v == ALL9)) ? 1'b1 : ovf_q;
        frozen_d = load_i ? 1'b0 : lap_i ? !frozen_q : frozen_q;
        lap_d    = (!load_i && lap_i && !frozen_q) ? count_q : lap_q;
    end

    always_ff @(posedge clk_i or negedge clr_ni) begin
        if (!clr_ni) begin
            tick_q   <= '0;
            count_q  <= '0;
            lap_q    <= '0;
            frozen_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            tick_q   <= tick_d;
            count_q  <= count_d;
            lap_q    <= lap_d;
            frozen_q <= frozen_d;
            ovf_q    <= ovf_d;
        end
    end

    assign count_o  = count_q;
    assign digits_o = frozen_q ? lap_q : count_q;
    assign frozen_o = frozen_q;
    assign ovf_o    = ovf_q;
endmodule

// File: tb/tb_stopwatch_lap.sv
// tb_stopwatch_lap: directed stimulus with a step-driven scoreboard on the wrapping
// instance plus direct checks on a wrapping and a saturating instance.
module tb_stopwatch_lap;
    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        go = 1'b0, down = 1'b0, load = 1'b0, lap = 1'b0;
    logic [11:0] preset = '0;
    logic [11:0] w_count, w_digits, s_count, s_digits;
    logic        w_frozen, w_step, w_ovf, w_zero;
    logic        s_frozen, s_step, s_ovf, s_zero;
    int          checks = 0, failures = 0, sat_steps = 0, base;
    logic        pend = 1'b0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    stopwatch_lap #(.TICK_DIV(4), .TW(3), .NDIG(3), .WRAP(1'b1)) u_w (
        .clk_i(clk), .clr_ni(clr_n), .go_i(go), .down_i(down), .load_i(load),
        .preset_i(preset), .lap_i(lap), .count_o(w_count), .digits_o(w_digits),
        .frozen_o(w_frozen), .step_o(w_step), .ovf_o(w_ovf), .zero_o(w_zero));

    stopwatch_lap #(.TICK_DIV(4), .TW(3), .NDIG(3), .WRAP(1'b0)) u_s (
        .clk_i(clk), .clr_ni(clr_n), .go_i(go), .down_i(down), .load_i(load),
        .preset_i(preset), .lap_i(lap), .count_o(s_count), .digits_o(s_digits),
        .frozen_o(s_frozen), .step_o(s_step), .ovf_o(s_ovf), .zero_o(s_zero));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset();
        chk("rst_count", 32'(w_count), 32'h000);
        chk("rst_digits", 32'(w_digits), 32'h000);
        chk("rst_frozen", 32'(w_frozen), 32'd0);
        chk("rst_ovf", 32'(w_ovf), 32'd0);
        chk("rst_step", 32'(w_step), 32'd0);
        chk("rst_zero", 32'(w_zero), 32'd1);
    endtask

    // Each step seen before an edge must show up as the next queued count after it.
    always @(negedge clk) begin
        if (pend) begin
            if (exp_q.size() == 0) chk("sb_unexpected_step", 32'(w_count), 32'hFFFF_FFFF);
            else chk("sb_count", 32'(w_count), 32'(exp_q.pop_front()));
        end
        pend = clr_n && w_step;
        if (s_step) sat_steps++;
    end

    initial begin
        cyc(2);
        chk_reset();
        clr_n = 1'b1;
        go = 1'b1;
        for (int i = 1; i <= 9; i++) exp_q.push_back(12'(i));
        exp_q.push_back(12'h010);
        cyc(40);
        chk("t1_count", 32'(w_count), 32'h010);
        chk("t1_sat_count", 32'(s_count), 32'h010);
        cyc(2);
        clr_n = 1'b0;
        #1;
        chk_reset();
        cyc(1);
        clr_n = 1'b1;
        go = 1'b0;
        load = 1'b1;
        preset = 12'h998;
        cyc(1);
        chk("t2_load", 32'(w_count), 32'h998);
        load = 1'b0;
        go = 1'b1;
        base = sat_steps;
        exp_q.push_back(12'h999);
        exp_q.push_back(12'h000);
        exp_q.push_back(12'h001);
        cyc(12);
        chk("t2_wrap_count", 32'(w_count), 32'h001);
        chk("t2_wrap_ovf", 32'(w_ovf), 32'd1);
        chk("t2_sat_count", 32'(s_count), 32'h999);
        chk("t2_sat_ovf", 32'(s_ovf), 32'd1);
        chk("t2_sat_steps", 32'(sat_steps - base), 32'd1);
        go = 1'b0;
        load = 1'b1;
        preset = 12'h010;
        down = 1'b1;
        cyc(1);
        chk("t3_ovf_cleared", 32'(w_ovf), 32'd0);
        load = 1'b0;
        go = 1'b1;
        exp_q.push_back(12'h009);
        exp_q.push_back(12'h008);
        cyc(8);
        chk("t3_down_count", 32'(w_count), 32'h008);
        go = 1'b0;
        load = 1'b1;
        preset = 12'h001;
        cyc(1);
        load = 1'b0;
        go = 1'b1;
        exp_q.push_back(12'h000);
        cyc(8);
        chk("t3_hold_count", 32'(w_count), 32'h000);
        chk("t3_zero", 32'(w_zero), 32'd1);
        chk("t3_ovf", 32'(w_ovf), 32'd0);
        down = 1'b0;
        go = 1'b0;
        load = 1'b1;
        preset = 12'h004;
        cyc(1);
        load = 1'b0;
        go = 1'b1;
        exp_q.push_back(12'h005);
        cyc(4);
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        chk("t4_frozen", 32'(w_frozen), 32'd1);
        for (int i = 6; i <= 9; i++) exp_q.push_back(12'(i));
        cyc(15);
        chk("t4_live_count", 32'(w_count), 32'h009);
        chk("t4_frozen_digits", 32'(w_digits), 32'h005);
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        chk("t4_unfrozen", 32'(w_frozen), 32'd0);
        chk("t4_digits_live", 32'(w_digits), 32'h009);
        cyc(2);
        chk("t4_step_cycle", 32'(w_step), 32'd1);
        exp_q.push_back(12'h010);
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        chk("t4_post_step_count", 32'(w_count), 32'h010);
        chk("t4_pre_step_capture", 32'(w_digits), 32'h009);
        load = 1'b1;
        lap = 1'b1;
        go = 1'b0;
        preset = 12'hC3F;
        cyc(1);
        load = 1'b0;
        lap = 1'b0;
        chk("t6_clamp", 32'(w_count), 32'h939);
        chk("t6_unfreeze", 32'(w_frozen), 32'd0);
        chk("t6_digits", 32'(w_digits), 32'h939);
        go = 1'b1;
        cyc(2);
        go = 1'b0;
        cyc(10);
        chk("t5_pause_count", 32'(w_count), 32'h939);
        chk("t5_pause_step", 32'(w_step), 32'd0);
        go = 1'b1;
        exp_q.push_back(12'h940);
        cyc(1);
        chk("t5_resume_wait", 32'(w_count), 32'h939);
        chk("t5_resume_step", 32'(w_step), 32'd1);
        cyc(1);
        chk("t5_resume_count", 32'(w_count), 32'h940);
        cyc(2);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
